// File: rtl/snake_matrix_scan.sv
// snake_matrix_scan: row-multiplexed 8x8 LED driver for the snake game state.
// Each frame is one SNAP cycle (all cell indices and game_over are captured)
// followed by DWELL cycles for each of rows 0..7. Because every output is a
// flop fed only from state and snapshot, input changes during a scan cannot
// tear the frame or reach the pins combinationally.
// step_tick pulses in the SNAP cycle once every STEP_FRAMES frames. It is the
// advance strobe for the game logic.
// Optional build macro SNAKE_FOOD_BLINK_EN: when defined, the food pixel is
// shown only while frame_cnt[1]=0, which makes it blink with a 4-frame period.
module snake_matrix_scan #(
  parameter int DWELL       = 4,  // cycles per row, 1..255
  parameter int STEP_FRAMES = 8   // frames per step_tick, 1..16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] idx_head,
  input  logic [5:0] idx0,
  input  logic [5:0] idx1,
  input  logic [5:0] idx2,
  input  logic [5:0] idx_food,
  input  logic       game_over,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic       frame_tick,
  output logic       step_tick
);

  typedef enum logic {
    SNAP = 1'b0,
    SCAN = 1'b1
  } phase_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] STEP_LAST  = 4'(STEP_FRAMES - 1);

  // Snapshot slot order: 0 head, 1..3 body segments, 4 food.
  localparam int FOOD_SLOT = 4;

  phase_e          phase_q, phase_d;
  logic [2:0]      row_q, row_d;
  logic [7:0]      dwell_q, dwell_d;
  logic [3:0]      frame_cnt_q, frame_cnt_d;
  logic [3:0]      step_cnt_q, step_cnt_d;
  logic [4:0][5:0] snap_idx_q, snap_idx_d;
  logic            snap_go_q, snap_go_d;

  logic [7:0]      row_sel_q, row_sel_d;
  logic [7:0]      col_data_q, col_data_d;
  logic            frame_tick_q, frame_tick_d;
  logic            step_tick_q, step_tick_d;

  // Column pattern of the current row, before game-over blanking.
  logic [7:0]      row_cols;
  logic            food_on;
  logic            blank;

  // State register: every flop, including the outputs, is cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the values from before the edge no matter how the statements are ordered.
  // NOTE: the snapshot is a handful of flops rather than a memory. It is reset to
  // zero like the counters, so the first frame never decodes stale power-up data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= SNAP;
      row_q        <= '0;
      dwell_q      <= '0;
      frame_cnt_q  <= '0;
      step_cnt_q   <= '0;
      snap_idx_q   <= '0;
      snap_go_q    <= 1'b0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_tick_q <= 1'b0;
      step_tick_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      frame_cnt_q  <= frame_cnt_d;
      step_cnt_q   <= step_cnt_d;
      snap_idx_q   <= snap_idx_d;
      snap_go_q    <= snap_go_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_tick_q <= frame_tick_d;
      step_tick_q  <= step_tick_d;
    end
  end

  // Next state: run the frame timeline and capture the inputs in SNAP.
  // NOTE: every variable gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    phase_d     = phase_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    frame_cnt_d = frame_cnt_q;
    step_cnt_d  = step_cnt_q;
    snap_idx_d  = snap_idx_q;
    snap_go_d   = snap_go_q;
    unique case (phase_q)
      SNAP: begin
        snap_idx_d  = {idx_food, idx2, idx1, idx0, idx_head};
        snap_go_d   = game_over;
        frame_cnt_d = frame_cnt_q + 4'd1;
        step_cnt_d  = (step_cnt_q == STEP_LAST) ? 4'd0 : step_cnt_q + 4'd1;
        phase_d     = SCAN;
        row_d       = 3'd0;
        dwell_d     = DWELL_LAST;
      end
      SCAN: begin
        if (dwell_q == 8'd0) begin
          // The dwell reloads on every row change. Row 7 returns to SNAP
          // and never wraps directly to row 0.
          dwell_d = DWELL_LAST;
          if (row_q == 3'd7) begin
            phase_d = SNAP;
            row_d   = 3'd0;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
      end
      default: phase_d = SNAP;
    endcase
  end

  // Food visibility: optionally blinks on frame_cnt[1].
`ifdef SNAKE_FOOD_BLINK_EN
  assign food_on = ~frame_cnt_q[1];
`else
  assign food_on = 1'b1;
`endif

  assign blank = snap_go_q & frame_cnt_q[2];

  // Row decode: OR together every snapshot cell on the current row.
  always_comb begin
    row_cols = '0;
    for (int i = 0; i < 5; i++) begin
      if (snap_idx_q[i][5:3] == row_q && (i != FOOD_SLOT || food_on)) begin
        row_cols[snap_idx_q[i][2:0]] = 1'b1;
      end
    end
  end

  // Output decode from the current registered state, registered on the next edge.
  always_comb begin
    row_sel_d    = '0;
    col_data_d   = '0;
    frame_tick_d = 1'b0;
    step_tick_d  = 1'b0;
    unique case (phase_q)
      SNAP: begin
        frame_tick_d = 1'b1;
        // snap_go_d is the game_over value being captured now, so it governs this frame.
        step_tick_d  = (step_cnt_q == STEP_LAST) && !snap_go_d;
      end
      SCAN: begin
        row_sel_d  = 8'b1 << row_q;
        col_data_d = blank ? 8'h00 : row_cols;
      end
      default: ;
    endcase
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_tick = frame_tick_q;
  assign step_tick  = step_tick_q;

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Self-checking bench for snake_matrix_scan. The stimulus process drives one
// frame at a time. For each frame it asks a frame-level model for that frame's
// expected output, one entry per cycle, and queues it. A separate monitor pops
// one entry at every falling edge and compares it with the DUT outputs.
module tb_snake_matrix_scan;

  localparam int DWELL       = 2;
  localparam int STEP_FRAMES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] idx_head = '0, idx0 = '0, idx1 = '0, idx2 = '0, idx_food = '0;
  logic       game_over = 1'b0;
  logic [7:0] row_sel, col_data;
  logic       frame_tick, step_tick;

  snake_matrix_scan #(.DWELL(DWELL), .STEP_FRAMES(STEP_FRAMES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_head   (idx_head),
    .idx0       (idx0),
    .idx1       (idx1),
    .idx2       (idx2),
    .idx_food   (idx_food),
    .game_over  (game_over),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_tick (frame_tick),
    .step_tick  (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_tick;
    logic       step_tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  int   frame_k  = 0;  // frames issued since the last reset release

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Frame-level model. Slot order is head, s0, s1, s2, food.
  task automatic push_frame(input logic [4:0][5:0] cells, input logic go);
    logic [7:0] rows [8];
    logic [3:0] fc;
    bit         step, blank, food_on;
    exp_t       e;
    fc      = 4'((frame_k + 1) % 16);  // frame counter value while this frame scans
    step    = ((frame_k % STEP_FRAMES) == STEP_FRAMES - 1) && !go;
    blank   = go && fc[2];
`ifdef SNAKE_FOOD_BLINK_EN
    food_on = !fc[1];
`else
    food_on = 1'b1;
`endif
    for (int r = 0; r < 8; r++) rows[r] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (i != 4 || food_on) rows[int'(cells[i]) / 8][int'(cells[i]) % 8] = 1'b1;
    end
    e = '{row_sel: 8'h00, col_data: 8'h00, frame_tick: 1'b1, step_tick: step};
    exp_q.push_back(e);
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < DWELL; d++) begin
        e = '{row_sel: 8'(1 << r), col_data: (blank ? 8'h00 : rows[r]),
              frame_tick: 1'b0, step_tick: 1'b0};
        exp_q.push_back(e);
      end
    end
    frame_k++;
  endtask

  task automatic drive(input logic [4:0][5:0] cells, input logic go);
    idx_head  = cells[0];
    idx0      = cells[1];
    idx1      = cells[2];
    idx2      = cells[3];
    idx_food  = cells[4];
    game_over = go;
  endtask

  // Called at a falling edge. It returns at the falling edge just before the
  // next frame's capture edge. When glitch is set, idx_head is changed to
  // new_head while row 1 is being displayed.
  task automatic run_frame(input logic [4:0][5:0] cells, input logic go,
                           input bit glitch, input logic [5:0] new_head);
    drive(cells, go);
    push_frame(cells, go);
    @(posedge clk);  // SNAP capture edge
    mon_en = 1'b1;
    for (int i = 0; i < 8 * DWELL; i++) begin
      @(posedge clk);
      if (glitch && i == DWELL) begin
        @(negedge clk);
        idx_head = new_head;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0][5:0] rand_cells();
    logic [4:0][5:0] c;
    for (int i = 0; i < 5; i++) c[i] = 6'($urandom_range(0, 63));
    return c;
  endfunction

  // Monitor: compare one queued expectation per cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL queue_underflow @%0t: DUT output with no expectation", $time);
        end else begin
          e = exp_q.pop_front();
          check("row_sel",    32'(row_sel),    32'(e.row_sel));
          check("col_data",   32'(col_data),   32'(e.col_data));
          check("frame_tick", 32'(frame_tick), 32'(e.frame_tick));
          check("step_tick",  32'(step_tick),  32'(e.step_tick));
        end
      end
    end
  end

  initial begin
    logic [4:0][5:0] pat;
    logic [4:0][5:0] c;
    pat = {6'o55, 6'o30, 6'o31, 6'o32, 6'o33};  // food, s2, s1, s0, head

    #1;
    check("rst_row_sel",    32'(row_sel),    32'h0);
    check("rst_col_data",   32'(col_data),   32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
    check("rst_step_tick",  32'(step_tick),  32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: the reference pattern. The head moves mid-scan and must not show until frame 1.
    run_frame(pat, 1'b0, 1'b1, 6'o77);
    c = pat;
    c[0] = 6'o77;
    run_frame(c, 1'b0, 1'b0, 6'o00);

    // Frames 2..23: random cells with an occasional game_over.
    for (int f = 2; f < 24; f++) begin
      run_frame(rand_cells(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 63)));
    end

    // Frames 24..31: game over is latched, which blanks some frames and suppresses step_tick.
    for (int f = 24; f < 32; f++) run_frame(pat, 1'b1, 1'b0, 6'o00);

    // Partial frame, then an asynchronous reset in the middle of row 4.
    drive(pat, 1'b0);
    push_frame(pat, 1'b0);
    @(posedge clk);
    repeat (4 * DWELL + 1) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_row_sel",    32'(row_sel),    32'h0);
    check("midrst_col_data",   32'(col_data),   32'h0);
    check("midrst_frame_tick", 32'(frame_tick), 32'h0);
    check("midrst_step_tick",  32'(step_tick),  32'h0);
    exp_q.delete();
    frame_k = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(pat, 1'b0, 1'b0, 6'o00);
    for (int f = 1; f < 10; f++) run_frame(rand_cells(), 1'b0, 1'b0, 6'o00);

    #1;
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the bench always ends with its summary.
  initial begin
    #200000;
    n_checks++;
    $display("FAIL timeout: simulation did not finish, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
